fm_dump_ctrl: RTL

- Sequencer for the FM receiver data-dump path: capture, hold, UART readout, return to idle.
- Captures a programmed number of bytes from one selected source (IQ or demodulated audio) into an internal byte buffer while the FM hardware is in the receive state.
- Raises a done interrupt when the capture completes, then streams the buffer to the UART side over a valid/ready handshake on command.
- Sits between the Arm-side control register decode and the UART TX framer.

---
 rtl/fm_dump_pkg.sv | 25 ++
 rtl/fm_dump_ram.sv | 23 ++
 rtl/fm_dump_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fm_dump_pkg.sv
// Shared encodings for the FM receiver data-dump sequencer.
package fm_dump_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_CAPTURE = 2'd1,
    OP_READ    = 2'd2,
    OP_ABORT   = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_READ    = 2'd3
  } dump_state_e;

  typedef enum logic {
    SRC_IQ    = 1'b0,
    SRC_AUDIO = 1'b1
  } src_e;

  localparam logic [3:0] FM_HW_STATE_RCEV = 4'b0010;

endpackage

// File: rtl/fm_dump_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port, no reset.
module fm_dump_ram #(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fm_dump_ctrl.sv
// FM data-dump sequencer: capture one source into a byte buffer, hold it,
// then stream it out over a valid/ready link on command.
module fm_dump_ctrl
  import fm_dump_pkg::*;
#(
  parameter int unsigned FM_ADDR_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  input  logic                   cmd_src,
  input  logic [FM_ADDR_WIDTH:0] cmd_len,
  input  logic [3:0]             FM_HW_state,
  input  logic                   iq_valid,
  input  logic [7:0]             iq_data,
  input  logic                   au_valid,
  input  logic [7:0]             au_data,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [1:0]             dump_state,
  output logic                   cmd_err,
  output logic                   Dump_Done_Interrupt,
  output logic                   Read_Done
);

  localparam int unsigned AW    = FM_ADDR_WIDTH;
  localparam int unsigned PW    = FM_ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << FM_ADDR_WIDTH;

  dump_state_e   state, state_n;
  src_e          src, src_n;
  logic [PW-1:0] len, len_n, wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic          load, load_n, tx_valid_n, err_n, done_n, rdone_n;
  logic [7:0]    tx_data_n, rd_q;
  logic          we_c, re_c, rcev_c, cap_ok_c, sel_valid_c;
  logic [AW-1:0] raddr_c;
  logic [7:0]    wdata_c;

  assign rcev_c      = (FM_HW_state == FM_HW_STATE_RCEV);
  assign cap_ok_c    = rcev_c && (cmd_len != '0) && (cmd_len <= PW'(DEPTH));
  assign sel_valid_c = (src == SRC_IQ) ? iq_valid : au_valid;
  assign wdata_c     = (src == SRC_IQ) ? iq_data : au_data;

  fm_dump_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (we_c),
    .waddr (AW'(wr_ptr)),
    .wdata (wdata_c),
    .re    (re_c),
    .raddr (raddr_c),
    .rdata (rd_q)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state               <= ST_IDLE;
      src                 <= SRC_IQ;
      len                 <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      load                <= 1'b0;
      tx_valid            <= 1'b0;
      tx_data             <= '0;
      busy                <= 1'b0;
      cmd_err             <= 1'b0;
      Dump_Done_Interrupt <= 1'b0;
      Read_Done           <= 1'b0;
    end else begin
      state               <= state_n;
      src                 <= src_n;
      len                 <= len_n;
      wr_ptr              <= wr_ptr_n;
      rd_ptr              <= rd_ptr_n;
      load                <= load_n;
      tx_valid            <= tx_valid_n;
      tx_data             <= tx_data_n;
      busy                <= (state_n != ST_IDLE);
      cmd_err             <= err_n;
      Dump_Done_Interrupt <= done_n;
      Read_Done           <= rdone_n;
    end
  end

  assign dump_state = state;

  // Next-state logic; ABORT outranks every same-cycle write, handshake or error.
  always_comb begin
    state_n    = state;
    src_n      = src;
    len_n      = len;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    load_n     = 1'b0;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    err_n      = 1'b0;
    done_n     = 1'b0;
    rdone_n    = 1'b0;
    we_c       = 1'b0;
    re_c       = 1'b0;
    raddr_c    = AW'(rd_ptr);

    if (cmd_valid && cmd_op == OP_ABORT) begin
      state_n    = ST_IDLE;
      tx_valid_n = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_op == OP_CAPTURE && cap_ok_c) begin
            state_n  = ST_CAPTURE;
            src_n    = src_e'(cmd_src);
            len_n    = cmd_len;
            wr_ptr_n = '0;
          end else if (cmd_valid && cmd_op != OP_NOP) begin
            err_n = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (!rcev_c) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
          end else begin
            if (sel_valid_c) begin
              we_c     = 1'b1;
              wr_ptr_n = wr_ptr + PW'(1);
              if (wr_ptr == len - PW'(1)) begin
                state_n = ST_FULL;
                done_n  = 1'b1;
              end
            end
            if (cmd_valid && cmd_op != OP_NOP) err_n = 1'b1;
          end
        end
        ST_FULL: begin
          if (cmd_valid && cmd_op == OP_READ) begin
            state_n  = ST_READ;
            rd_ptr_n = '0;
            re_c     = 1'b1;
            raddr_c  = '0;
            load_n   = 1'b1;
          end else if (cmd_valid && cmd_op == OP_CAPTURE) begin
            if (cap_ok_c) begin
              state_n  = ST_CAPTURE;
              src_n    = src_e'(cmd_src);
              len_n    = cmd_len;
              wr_ptr_n = '0;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        ST_READ: begin
          // Prefetch the next byte on each handshake so it lands two cycles later.
          if (load) begin
            tx_valid_n = 1'b1;
            tx_data_n  = rd_q;
          end else if (tx_valid && tx_ready) begin
            tx_valid_n = 1'b0;
            if (rd_ptr == len - PW'(1)) begin
              state_n = ST_IDLE;
              rdone_n = 1'b1;
            end else begin
              rd_ptr_n = rd_ptr + PW'(1);
              re_c     = 1'b1;
              raddr_c  = AW'(rd_ptr + PW'(1));
              load_n   = 1'b1;
            end
          end
          if (cmd_valid && cmd_op != OP_NOP) err_n = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule
